// File: rtl/decoder_7segment.sv
// Registered hex/BCD to seven-segment decoder driving one display digit.
// Output bits are {g,f,e,d,c,b,a}; polarity and hex support are set by parameters.
module decoder_7segment #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] In,
    output logic [6:0] segmentDisplay
);

    localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] litPattern;
    logic [6:0] segmentNext;

    // litPattern is active-high; an X/Z code falls to the default and stays dark.
    always_comb begin
        litPattern = 7'h00;
        case (In)
            4'd0:    litPattern = 7'h3F;
            4'd1:    litPattern = 7'h06;
            4'd2:    litPattern = 7'h5B;
            4'd3:    litPattern = 7'h4F;
            4'd4:    litPattern = 7'h66;
            4'd5:    litPattern = 7'h6D;
            4'd6:    litPattern = 7'h7D;
            4'd7:    litPattern = 7'h07;
            4'd8:    litPattern = 7'h7F;
            4'd9:    litPattern = 7'h6F;
            4'd10:   litPattern = HEX_EN ? 7'h77 : 7'h00;
            4'd11:   litPattern = HEX_EN ? 7'h7C : 7'h00;
            4'd12:   litPattern = HEX_EN ? 7'h39 : 7'h00;
            4'd13:   litPattern = HEX_EN ? 7'h5E : 7'h00;
            4'd14:   litPattern = HEX_EN ? 7'h79 : 7'h00;
            4'd15:   litPattern = HEX_EN ? 7'h71 : 7'h00;
            default: litPattern = 7'h00;
        endcase
        segmentNext = ACTIVE_LOW ? ~litPattern : litPattern;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segmentDisplay <= BLANK;
        end else begin
            segmentDisplay <= segmentNext;
        end
    end

endmodule

// File: tb/tb_decoder_7segment.sv
// Directed bench for decoder_7segment: three instances cover active-low hex,
// active-low decimal-only and active-high hex configurations.
module tb_decoder_7segment;

    logic       clk;
    logic       rst_n;
    logic [3:0] In;
    logic [6:0] segLowHex;
    logic [6:0] segLowDec;
    logic [6:0] segHighHex;

    int errors = 0;
    int checks = 0;

    logic [6:0] lowTab  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] highTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [6:0] prevLowHex;
    logic [6:0] prevLowDec;
    logic [6:0] prevHighHex;

    decoder_7segment #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dutLowHex (
        .clk(clk), .rst_n(rst_n), .In(In), .segmentDisplay(segLowHex)
    );
    decoder_7segment #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) dutLowDec (
        .clk(clk), .rst_n(rst_n), .In(In), .segmentDisplay(segLowDec)
    );
    decoder_7segment #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dutHighHex (
        .clk(clk), .rst_n(rst_n), .In(In), .segmentDisplay(segHighHex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [6:0] eLowHex,
                            input logic [6:0] eLowDec, input logic [6:0] eHighHex);
        check({tag, "/lowHex"},  segLowHex,  eLowHex);
        check({tag, "/lowDec"},  segLowDec,  eLowDec);
        check({tag, "/highHex"}, segHighHex, eHighHex);
    endtask

    // Apply a code, confirm nothing moves before the edge, then check the decode.
    task automatic step(input logic [3:0] code);
        logic [6:0] eLowHex;
        logic [6:0] eLowDec;
        logic [6:0] eHighHex;
        In = code;
        #1;
        checkAll($sformatf("hold_in%0d", code), prevLowHex, prevLowDec, prevHighHex);
        @(posedge clk);
        #1;
        eLowHex  = lowTab[code];
        eLowDec  = (code >= 4'd10) ? 7'h7F : lowTab[code];
        eHighHex = highTab[code];
        checkAll($sformatf("decode_in%0d", code), eLowHex, eLowDec, eHighHex);
        $display("step In=%0d lowHex=%h lowDec=%h highHex=%h", code, segLowHex, segLowDec, segHighHex);
        prevLowHex  = eLowHex;
        prevLowDec  = eLowDec;
        prevHighHex = eHighHex;
    endtask

    initial begin
        rst_n = 1'b1;
        In    = 4'd8;
        #1 rst_n = 1'b0;
        #1;
        checkAll("reset_async", 7'h7F, 7'h7F, 7'h00);
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset_held", 7'h7F, 7'h7F, 7'h00);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkAll("release_wait", 7'h7F, 7'h7F, 7'h00);
        @(posedge clk);
        #1;
        checkAll("release_first", 7'h00, 7'h00, 7'h7F);
        prevLowHex  = 7'h00;
        prevLowDec  = 7'h00;
        prevHighHex = 7'h7F;

        for (int i = 0; i < 16; i++) step(4'(i));
        step(4'd5);
        step(4'd1);

        // Reset between edges while showing 3 must blank at once.
        step(4'd3);
        #2 rst_n = 1'b0;
        #1;
        checkAll("midreset_blank", 7'h7F, 7'h7F, 7'h00);
        #2 rst_n = 1'b1;
        prevLowHex  = 7'h7F;
        prevLowDec  = 7'h7F;
        prevHighHex = 7'h00;

        for (int i = 0; i <= 9; i++) step(4'(i));
        for (int i = 8; i >= 0; i--) step(4'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
